cpu_regfile_sb: RTL and testbench
=================================

Name: cpu_regfile_sb

Overview:
Parametrised general-purpose register file with an integrated write-pending scoreboard for the RV32 pipeline.
- Provides NRD combinational read ports and NWR synchronous write-back ports.
- Tracks per-register "result pending" bits, set at issue and cleared at write-back, so decode can detect RAW hazards.
- Sits between decode/issue (reads, issue marks) and the write-back stage(s) (writes, clears).

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers; register 0 is hardwired zero.
AW, 5, register address width; must satisfy 2**AW >= NREG.
NRD, 4, number of read ports.
NWR, 2, number of write ports; a higher port index has higher priority.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
raddr  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
rdata  output  NRD*XLEN  packed read data; port i uses [i*XLEN +: XLEN].
rbusy  output  NRD  port i addresses a register whose result is still pending.
wen  input  NWR  per-port write enable.
waddr  input  NWR*AW  packed write addresses.
wdata  input  NWR*XLEN  packed write data.
issue_en  input  1  mark issue_rd as pending at the next edge.
issue_rd  input  AW  destination register of the issuing instruction.
flush  input  1  synchronous clear of all pending bits (pipeline flush).
busy_cnt  output  AW+1  registered count of pending registers.
busy_vec  output  NREG  registered pending bit per register.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0, busy_cnt = 0. rdata = 0 for every port and rbusy = 0 while reset is held.
- Reads are combinational, with 0-cycle latency.
  - raddr = 0 -> rdata = 0 and rbusy = 0.
  - raddr >= NREG -> rdata = 0 and rbusy = 0.
- Writes occur on the rising edge when wen[j] = 1.
  - Writes to address 0 or to an address >= NREG are ignored.
  - If two ports write the same address in the same cycle, the highest-index port's data is stored.
- Write-back clears the pending bit: busy[waddr[j]] is cleared at the same edge as the write, for every enabled port with a valid, nonzero address.
- Issue sets the pending bit: issue_en with a nonzero, valid issue_rd sets busy[issue_rd] at the edge. issue_rd = 0 has no effect.
- Set and clear of the same register in one cycle: the set wins, so the bit ends at 1 (a newer producer is now outstanding).
- flush has priority over both issue and clear: all busy bits become 0 at the edge. Register contents are unaffected, and writes in the same cycle still commit.
- busy_cnt equals the popcount of busy_vec after each edge, computed from the next-state vector. It never exceeds NREG-1.
- Without bypass: rbusy[i] = busy[raddr[i]].
- Bypassing is governed by the optional feature below.
- Reset mid-operation: all state clears immediately; no pending write completes.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wen[j] is set and waddr[j] == raddr[i] != 0 in the current cycle, rdata[i] = wdata of the highest-index matching port. rbusy[i] is forced to 0 for that port unless issue_en marks the same register in the same cycle.
- Undefined: reads return only stored contents; rbusy[i] remains 1 during the write-back cycle and drops the following cycle.

Test Plan:
- Reset, then read all addresses on all ports -> rdata = 0, rbusy = 0, busy_cnt = 0; write 0xDEADBEEF to x0 -> x0 still reads 0.
- issue_en with rd = 5, next cycle read x5 -> rbusy = 1, busy_cnt = 1; wen[0] with x5 = 0x1234 -> after the edge x5 = 0x1234, rbusy = 0, busy_cnt = 0.
- wen[0] and wen[1] both target x7 with 0xAAAA0000 / 0x5555FFFF -> x7 = 0x5555FFFF.
- Same cycle: issue x9 and write back x9 = 0x42 -> x9 = 0x42 and busy[9] = 1 (set wins), busy_cnt = 1.
- Issue x1, x2, x3, then flush in the same cycle as issuing x4 -> busy_vec = 0 and busy_cnt = 0 after the flush edge.
- With REGFILE_BYPASS_EN, in the write cycle of x10 = 0xCAFEF00D, read port 2 at x10 -> rdata = 0xCAFEF00D, rbusy = 0 in that cycle; without the macro -> old value and rbusy = 1.

Source files
------------

// File: rtl/cpu_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module : cpu_regfile_sb
// Desc   : RV32 register file with result-pending scoreboard.
//          Optional macro REGFILE_BYPASS_EN adds write-through read forwarding.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 4,
  parameter int NWR  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [AW:0]         busy_cnt,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;

  // x0 and addresses beyond the implemented range never hold state
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // ascending port order lets the highest-index writer land last
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && addr_ok(waddr[j*AW +: AW])) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en && addr_ok(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_cnt_d = '0;
    for (int k = 0; k < NREG; k++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = busy_cnt_q;

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd_val;
      logic            rb_val;

      always_comb begin
        ra     = raddr[i*AW +: AW];
        rd_val = '0;
        rb_val = 1'b0;
        if (rst_n && addr_ok(ra)) begin
          rd_val = regs_q[ra];
          rb_val = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
          // a same-cycle issue to this register re-marks it as pending
          for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
              rd_val = wdata[j*XLEN +: XLEN];
              rb_val = issue_en && (issue_rd == ra);
            end
          end
`endif
        end
      end

      assign rdata[i*XLEN +: XLEN] = rd_val;
      assign rbusy[i]              = rb_val;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_regfile_sb
// Desc   : self-checking bench for cpu_regfile_sb (reduced NREG for range edges)
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 28;
  localparam int AW   = 5;
  localparam int NRD  = 4;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic [AW:0]         busy_cnt;
  logic [NREG-1:0]     busy_vec;

  always #5 clk = ~clk;

  cpu_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
    .issue_rd(issue_rd), .flush(flush), .busy_cnt(busy_cnt), .busy_vec(busy_vec)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [XLEN-1:0] m_regs [32];
  logic [31:0]     m_busy;
  logic [XLEN-1:0] ed;
  logic            eb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // per-register view: last writer wins, then flush > issue > write-back clear
  task automatic model_update();
    logic [31:0] nb;
    nb = m_busy;
    for (int r = 1; r < NREG; r++) begin
      int w;
      bit hit;
      w   = -1;
      hit = issue_en && (int'(issue_rd) == r);
      for (int j = 0; j < NWR; j++)
        if (wen[j] && (int'(waddr[j*AW +: AW]) == r)) w = j;
      if (w >= 0) m_regs[r] = wdata[w*XLEN +: XLEN];
      nb[r] = flush ? 1'b0 : hit ? 1'b1 : (w >= 0) ? 1'b0 : m_busy[r];
    end
    m_busy = nb;
  endtask

  function automatic void exp_read(input int i, output logic [XLEN-1:0] d, output logic b);
    int a;
    a = int'(raddr[i*AW +: AW]);
    d = '0;
    b = 1'b0;
    if (rst_n === 1'b1 && a != 0 && a < NREG) begin
      d = m_regs[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wen[j] && (int'(waddr[j*AW +: AW]) == a)) begin
          d = wdata[j*XLEN +: XLEN];
          b = issue_en && (int'(issue_rd) == a);
        end
`endif
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NRD; i++) begin
        exp_read(i, ed, eb);
        chk($sformatf("rdata%0d", i), 64'(rdata[i*XLEN +: XLEN]), 64'(ed));
        chk($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(eb));
      end
      chk("busy_vec", 64'(busy_vec), 64'(m_busy[NREG-1:0]));
      chk("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
    end
  end

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
    wen[j] = 1'b1;
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int i, input int a);
    raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a);
    issue_en = 1'b1;
    issue_rd = AW'(a);
  endtask

  initial begin
    idle();
    raddr = '0;
    rst_n = 1'b0;
    model_clear();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    chk("reset_vec", 64'(busy_vec), 64'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      for (int i = 0; i < NRD; i++) rd(i, (a + i * 8) % 32);
      tick();
    end

    wr(0, 0, 32'hDEADBEEF); wr(1, 30, 32'h12345678);
    tick(); idle(); rd(0, 0); rd(1, 30); #1;
    chk("x0_zero", 64'(rdata[0 +: XLEN]), 64'd0);
    chk("x30_invalid", 64'(rdata[XLEN +: XLEN]), 64'd0);

    iss(5); tick(); idle(); rd(0, 5); #1;
    chk("x5_busy", 64'(rbusy[0]), 64'd1);
    chk("x5_cnt", 64'(busy_cnt), 64'd1);
    wr(0, 5, 32'h1234); #1;
`ifdef REGFILE_BYPASS_EN
    chk("x5_wb_busy", 64'(rbusy[0]), 64'd0);
`else
    chk("x5_wb_busy", 64'(rbusy[0]), 64'd1);
`endif
    tick(); idle(); #1;
    chk("x5_data", 64'(rdata[0 +: XLEN]), 64'h1234);
    chk("x5_free", 64'(rbusy[0]), 64'd0);
    chk("x5_cnt0", 64'(busy_cnt), 64'd0);

    wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h5555FFFF);
    tick(); idle(); rd(1, 7); #1;
    chk("x7_prio", 64'(rdata[XLEN +: XLEN]), 64'h5555FFFF);

    iss(9); wr(1, 9, 32'h42);
    tick(); idle(); rd(2, 9); #1;
    chk("x9_data", 64'(rdata[2*XLEN +: XLEN]), 64'h42);
    chk("x9_setwins", 64'(busy_vec[9]), 64'd1);
    chk("x9_cnt", 64'(busy_cnt), 64'd1);

    iss(1); tick(); iss(2); tick(); iss(3); tick(); idle(); #1;
    chk("cnt4", 64'(busy_cnt), 64'd4);
    iss(4); flush = 1'b1; wr(0, 11, 32'h77);
    tick(); idle(); rd(3, 11); #1;
    chk("flush_vec", 64'(busy_vec), 64'd0);
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    chk("flush_wr", 64'(rdata[3*XLEN +: XLEN]), 64'h77);

    iss(10); tick(); idle(); rd(2, 10); wr(0, 10, 32'hCAFEF00D); #1;
`ifdef REGFILE_BYPASS_EN
    chk("x10_fwd", 64'(rdata[2*XLEN +: XLEN]), 64'hCAFEF00D);
    chk("x10_fwd_busy", 64'(rbusy[2]), 64'd0);
`else
    chk("x10_old", 64'(rdata[2*XLEN +: XLEN]), 64'd0);
    chk("x10_old_busy", 64'(rbusy[2]), 64'd1);
`endif
    tick(); idle(); #1;
    chk("x10_data", 64'(rdata[2*XLEN +: XLEN]), 64'hCAFEF00D);
    chk("x10_free", 64'(rbusy[2]), 64'd0);

    iss(13); wr(1, 13, 32'h99); wr(0, 13, 32'h11); rd(3, 13);
    tick(); idle(); #1;
    chk("x13_data", 64'(rdata[3*XLEN +: XLEN]), 64'h99);
    chk("x13_busy", 64'(busy_vec[13]), 64'd1);

    iss(0); tick(); iss(30); tick(); idle(); #1;
    chk("bad_issue_cnt", 64'(busy_cnt), 64'd1);

    for (int r = 1; r < NREG; r++) begin
      iss(r); tick();
    end
    idle(); rd(0, 27); rd(1, 28); #1;
    chk("full_cnt", 64'(busy_cnt), 64'd27);
    chk("x27_busy", 64'(rbusy[0]), 64'd1);
    chk("x28_range", 64'(rbusy[1]), 64'd0);
    wr(0, 27, 32'h27); wr(1, 26, 32'h26); iss(26);
    tick(); idle(); #1;

    rd(0, 20); rd(1, 5); wr(0, 20, 32'hBAD0BAD0); iss(20); #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_hold_rd", 64'(rdata[0 +: XLEN]), 64'd0);
    chk("rst_hold_busy", 64'(rbusy[0]), 64'd0);
    tick();
    idle(); rst_n = 1'b1; #1;
    chk("rst_x20", 64'(rdata[0 +: XLEN]), 64'd0);
    chk("rst_x5", 64'(rdata[XLEN +: XLEN]), 64'd0);
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    repeat (3) tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
